// File: rtl/exmem_pkg.sv
// Shared encodings for the EX/MEM stage: operation classes, function codes
// and the data-memory handshake state enumeration.
package exmem_pkg;

    localparam logic [1:0] OP_R    = 2'b00;
    localparam logic [1:0] OP_I    = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b10;
    localparam logic [1:0] OP_CTRL = 2'b11;

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SUB  = 3'd1;
    localparam logic [2:0] F_AND  = 3'd2;
    localparam logic [2:0] F_OR   = 3'd3;
    localparam logic [2:0] F_XOR  = 3'd4;
    localparam logic [2:0] F_SLL  = 3'd5;
    localparam logic [2:0] F_SRL  = 3'd6;
    localparam logic [2:0] F_SLTU = 3'd7;

    localparam logic [2:0] FI_ADDI = 3'd0;
    localparam logic [2:0] FI_LUI  = 3'd1;

    localparam logic [2:0] FM_LOAD  = 3'd0;
    localparam logic [2:0] FM_STORE = 3'd1;

    localparam logic [2:0] FC_BNE = 3'd0;
    localparam logic [2:0] FC_JMP = 3'd1;
    localparam logic [2:0] FC_JR  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } mem_state_e;

endpackage

// File: rtl/exmem_alu.sv
// Combinational ALU for register (op 00) and immediate (op 01) instructions.
// All arithmetic wraps modulo 2^DW; other op classes yield zero.
module exmem_alu
    import exmem_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [1:0]      op,
    input  logic [2:0]      funct,
    input  logic [DW-1:0]   reg1,
    input  logic [DW-1:0]   reg2,
    input  logic [DW/2-1:0] idata,
    output logic [DW-1:0]   result
);

    localparam int SW = $clog2(DW);

    logic [DW-1:0] imm_z;
    logic [SW-1:0] shamt;

    assign imm_z = {{(DW/2){1'b0}}, idata};
    assign shamt = idata[SW-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD:   result = reg1 + reg2;
                    F_SUB:   result = reg1 - reg2;
                    F_AND:   result = reg1 & reg2;
                    F_OR:    result = reg1 | reg2;
                    F_XOR:   result = reg1 ^ reg2;
                    F_SLL:   result = reg1 << shamt;
                    F_SRL:   result = reg1 >> shamt;
                    F_SLTU:  result = {{(DW-1){1'b0}}, (reg1 < reg2)};
                    default: result = '0;
                endcase
            end
            OP_I: begin
                case (funct)
                    FI_ADDI: result = reg1 + imm_z;
                    FI_LUI:  result = {idata, {(DW/2){1'b0}}};
                    default: result = reg1 & imm_z;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: single-cycle ALU/branch results, and loads/stores
// issued over an APB-style master with a bounded wait before timing out.
module exmem_stage
    import exmem_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 6,
    parameter int PCW      = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [2:0]      funct,
    input  logic [DW-1:0]   reg1,
    input  logic [DW-1:0]   reg2,
    input  logic [DW/2-1:0] idata,
    input  logic [AW-1:0]   memaddr,
    input  logic [PCW-1:0]  pc_in,
    output logic            out_valid,
    output logic [DW-1:0]   wb_data,
    output logic            wb_we,
    output logic [PCW-1:0]  pc_out,
    output logic            mem_err,
    output logic [AW-1:0]   paddr,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [DW-1:0]   pwdata,
    input  logic [DW-1:0]   prdata,
    input  logic            pready
);

    localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    mem_state_e     state;
    logic [WCW-1:0] wait_cnt;
    logic [PCW-1:0] mem_pc;
    logic [DW-1:0]  alu_res;
    logic [PCW-1:0] pc_next;
    logic [4:0]     boff;
    logic           is_mem;
    logic           alu_we;

    exmem_alu #(.DW(DW)) u_alu (
        .op     (op),
        .funct  (funct),
        .reg1   (reg1),
        .reg2   (reg2),
        .idata  (idata),
        .result (alu_res)
    );

    assign in_ready = rst && (state == ST_IDLE);
    assign psel     = (state != ST_IDLE);
    assign penable  = (state == ST_ACCESS);
    assign is_mem   = (op == OP_MEM) && ((funct == FM_LOAD) || (funct == FM_STORE));
    assign alu_we   = (op == OP_R) || ((op == OP_I) && (funct <= FI_LUI));
    assign boff     = 5'(idata);

    always_comb begin
        pc_next = pc_in + PCW'(1);
        if (op == OP_CTRL) begin
            case (funct)
                FC_BNE: if (reg1 != reg2)
                            pc_next = pc_in + PCW'(1) + {{(PCW-5){boff[4]}}, boff};
                FC_JMP: pc_next = pc_in + PCW'(idata);
                FC_JR:  pc_next = PCW'(reg1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            mem_pc    <= '0;
            out_valid <= 1'b0;
            wb_data   <= '0;
            wb_we     <= 1'b0;
            pc_out    <= '0;
            mem_err   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // in_ready is implied here: rst is high and we are idle
                    if (in_valid) begin
                        if (is_mem) begin
                            state    <= ST_SETUP;
                            paddr    <= memaddr;
                            pwrite   <= (funct == FM_STORE);
                            pwdata   <= reg2;
                            mem_pc   <= pc_next;
                            wait_cnt <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            wb_data   <= alu_res;
                            wb_we     <= alu_we;
                            pc_out    <= pc_next;
                            mem_err   <= 1'b0;
                        end
                    end
                end
                ST_SETUP: state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (pready) begin
                        out_valid <= 1'b1;
                        wb_we     <= !pwrite;
                        if (!pwrite) wb_data <= prdata;
                        pc_out    <= mem_pc;
                        mem_err   <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                        out_valid <= 1'b1;
                        wb_we     <= 1'b0;
                        pc_out    <= mem_pc;
                        mem_err   <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: a driver issues directed and random
// instructions and plays the APB slave; a monitor checks every result pulse.
module tb_exmem_stage;

    localparam int DW       = 16;
    localparam int AW       = 6;
    localparam int PCW      = 32;
    localparam int MAX_WAIT = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [2:0]      funct;
    logic [DW-1:0]   reg1;
    logic [DW-1:0]   reg2;
    logic [DW/2-1:0] idata;
    logic [AW-1:0]   memaddr;
    logic [PCW-1:0]  pc_in;
    logic            out_valid;
    logic [DW-1:0]   wb_data;
    logic            wb_we;
    logic [PCW-1:0]  pc_out;
    logic            mem_err;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [DW-1:0]  data;
        logic           we;
        logic [PCW-1:0] pc;
        logic           err;
    } exp_t;

    exp_t sbq[$];

    exmem_stage #(
        .DW       (DW),
        .AW       (AW),
        .PCW      (PCW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct     (funct),
        .reg1      (reg1),
        .reg2      (reg2),
        .idata     (idata),
        .memaddr   (memaddr),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .pc_out    (pc_out),
        .mem_err   (mem_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Reference behaviour from the instruction-set rules, in plain integer arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [2:0] f,
                                   input logic [15:0] r1, input logic [15:0] r2,
                                   input logic [7:0] im, input logic [31:0] pc,
                                   input int unsigned w, input logic [15:0] rd);
        exp_t   e;
        longint m  = 65536;
        longint p  = 64'h1_0000_0000;
        longint a  = longint'(r1);
        longint b  = longint'(r2);
        longint i  = longint'(im);
        longint pn = longint'(pc);
        longint sh = i % 16;
        longint off;
        longint res = 0;
        e.we  = 1'b0;
        e.err = 1'b0;
        pn    = (pn + 1) % p;
        case (o)
            2'd0: begin
                e.we = 1'b1;
                case (f)
                    3'd0: res = (a + b) % m;
                    3'd1: res = (a - b + m) % m;
                    3'd2: res = a & b;
                    3'd3: res = a | b;
                    3'd4: res = a ^ b;
                    3'd5: res = (a * (longint'(1) << sh)) % m;
                    3'd6: res = a / (longint'(1) << sh);
                    default: res = (a < b) ? 1 : 0;
                endcase
            end
            2'd1: begin
                if (f == 3'd0) begin e.we = 1'b1; res = (a + i) % m; end
                else if (f == 3'd1) begin e.we = 1'b1; res = i * 256; end
            end
            2'd2: begin
                if (f <= 3'd1) begin
                    if (w >= MAX_WAIT) e.err = 1'b1;
                    else if (f == 3'd0) begin e.we = 1'b1; res = longint'(rd); end
                end
            end
            default: begin
                if (f == 3'd0 && a != b) begin
                    off = i % 32;
                    if (off >= 16) off = off - 32;
                    pn = (longint'(pc) + 1 + off + p) % p;
                end else if (f == 3'd1) begin
                    pn = (longint'(pc) + i) % p;
                end else if (f == 3'd2) begin
                    pn = a;
                end
            end
        endcase
        e.data = 16'(res);
        e.pc   = 32'(pn);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid) begin
            exp_t e;
            if (sbq.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                chk("pc_out", pc_out, e.pc);
                chk("mem_err", 32'(mem_err), 32'(e.err));
                chk("psel_at_result", 32'(psel), 32'd0);
                if (e.we) chk("wb_data", 32'(wb_data), 32'(e.data));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [2:0] f,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input logic [7:0] im, input logic [5:0] ma,
                         input logic [31:0] pc, input int unsigned w,
                         input logic [15:0] rd);
        bit is_mem;
        is_mem = (o == 2'd2) && (f <= 3'd1);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        funct    = f;
        reg1     = r1;
        reg2     = r2;
        idata    = im;
        memaddr  = ma;
        pc_in    = pc;
        sbq.push_back(model(o, f, r1, r2, im, pc, w, rd));
        @(posedge clk);
        if (is_mem) begin
            // upstream may keep presenting work while busy; it must be ignored
            @(negedge clk);
            in_valid = 1'($urandom);
            op       = 2'($urandom);
            funct    = 3'($urandom);
            reg2     = 16'($urandom);
            chk("psel_setup", 32'(psel), 32'd1);
            chk("penable_setup", 32'(penable), 32'd0);
            chk("in_ready_setup", 32'(in_ready), 32'd0);
            chk("paddr_setup", 32'(paddr), 32'(ma));
            chk("pwrite_setup", 32'(pwrite), 32'(f == 3'd1));
            if (f == 3'd1) chk("pwdata_setup", 32'(pwdata), 32'(r2));
            @(posedge clk);
            for (int unsigned i = 0; i < MAX_WAIT; i++) begin
                @(negedge clk);
                chk("psel_access", 32'(psel), 32'd1);
                chk("penable_access", 32'(penable), 32'd1);
                chk("in_ready_access", 32'(in_ready), 32'd0);
                chk("paddr_access", 32'(paddr), 32'(ma));
                prdata = (i == w) ? rd : 16'($urandom);
                pready = (i == w);
                @(posedge clk);
                #1 pready = 1'b0;
                if (i == w) break;
            end
        end
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        funct    = '0;
        reg1     = '0;
        reg2     = '0;
        idata    = '0;
        memaddr  = '0;
        pc_in    = '0;
        prdata   = '0;
        pready   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // directed: add, wrap, bne taken, jr, load with 2 waits, store timeout
        issue(2'd0, 3'd0, 16'h0003, 16'h0004, 8'h00, 6'h00, 32'h20, 0, 16'h0);
        issue(2'd0, 3'd0, 16'hFFFF, 16'h0001, 8'h00, 6'h00, 32'h30, 0, 16'h0);
        issue(2'd3, 3'd0, 16'h0001, 16'h0002, 8'h1E, 6'h00, 32'h10, 0, 16'h0);
        issue(2'd3, 3'd2, 16'h0040, 16'h0000, 8'h00, 6'h00, 32'h99, 0, 16'h0);
        issue(2'd2, 3'd0, 16'h0000, 16'h1234, 8'h00, 6'h05, 32'h40, 2, 16'hBEEF);
        issue(2'd2, 3'd1, 16'h0000, 16'h5A5A, 8'h00, 6'h2A, 32'h50, 4, 16'h0);
        issue(2'd0, 3'd7, 16'h0005, 16'h0005, 8'h00, 6'h00, 32'hFFFF_FFFF, 0, 16'h0);

        for (int n = 0; n < 400; n++) begin
            logic [1:0]  o;
            logic [2:0]  f;
            logic [15:0] r1;
            logic [15:0] r2;
            o  = 2'($urandom);
            f  = 3'($urandom);
            if (o == 2'd2 && $urandom_range(0, 3) != 0) f = 3'($urandom_range(0, 1));
            r1 = 16'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) bubble();
            issue(o, f, r1, r2, 8'($urandom), 6'($urandom), 32'($urandom),
                  $urandom_range(0, MAX_WAIT + 1), 16'($urandom));
        end

        bubble();
        bubble();

        // reset in the middle of an ACCESS phase: aborted load must vanish
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'd2;
        funct    = 3'd0;
        memaddr  = 6'h11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_psel", 32'(psel), 32'd0);
        chk("midrst_penable", 32'(penable), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_paddr", 32'(paddr), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("in_ready_after_midrst", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("no_out_valid_after_rst", 32'(out_valid), 32'd0);
            chk("no_psel_after_rst", 32'(psel), 32'd0);
        end

        issue(2'd1, 3'd1, 16'h0000, 16'h0000, 8'hA5, 6'h00, 32'h0, 0, 16'h0);
        bubble();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
